// File: rtl/svtypes_chan_bank_pkg.sv
// ----------------------------------------------------------------------------
// svtypes_pkg
// Shared types and constants for the svtypes channel bank.
//   bank_state_t  : bank sequencing state (INIT sweep, then IDLE service)
//   svt_user_t    : single-bit user typedef kept for the typedef regressions
//   DEFAULT_WIDTH : default channel data width
// ----------------------------------------------------------------------------
package svtypes_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } bank_state_t;

    typedef logic svt_user_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : svtypes_pkg

// File: rtl/svtypes_chan_bank_if.sv
// ----------------------------------------------------------------------------
// svtypes_chan_bank_if
// Procedural write bus of the channel bank.
//   wr_valid : write request            (master -> slave)
//   wr_chan  : target channel index     (master -> slave)
//   wr_data  : write data               (master -> slave)
//   wr_ready : bank can accept a write  (slave -> master)
//   wr_err   : one-cycle pulse, accepted write was dropped (slave -> master)
// ----------------------------------------------------------------------------
interface svtypes_chan_bank_if #(
    parameter int WIDTH = 8,
    parameter int NCHAN = 4
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic             wr_valid;
    logic             wr_ready;
    logic [CW-1:0]    wr_chan;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;

    modport master (
        output wr_valid,
        output wr_chan,
        output wr_data,
        input  wr_ready,
        input  wr_err
    );

    modport slave (
        input  wr_valid,
        input  wr_chan,
        input  wr_data,
        output wr_ready,
        output wr_err
    );

endinterface : svtypes_chan_bank_if

// File: rtl/svtypes_chan_bank_cell.sv
// ----------------------------------------------------------------------------
// svtypes_chan_cell
// One storage channel of the bank.
//   IS_NET = 0 : variable channel. Holds a value; a continuous drive
//                overrides storage and wins over a simultaneous write.
//   IS_NET = 1 : net channel. No storage; value is cont_data_i when driven,
//                INIT_VAL otherwise.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   wr_en_i       : write strobe (procedural or init-sweep write)
//   wr_data_i     : write data
//   cont_en_i     : continuous-drive enable
//   cont_data_i   : continuous-drive value
//   value_o       : current channel value
//   conflict_o    : pulse, variable channel is being continuously driven
// ----------------------------------------------------------------------------
module svtypes_chan_cell #(
    parameter int               WIDTH    = 8,
    parameter bit               IS_NET   = 1'b0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             cont_en_i,
    input  logic [WIDTH-1:0] cont_data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             conflict_o
);

    logic [WIDTH-1:0] storage_q;
    logic [WIDTH-1:0] storage_d;

    // Next-state storage: continuous drive beats any write; net cells never store.
    always_comb begin
        storage_d = storage_q;
        if ((IS_NET == 1'b0) && cont_en_i) begin
            storage_d = cont_data_i;
        end else if ((IS_NET == 1'b0) && wr_en_i) begin
            storage_d = wr_data_i;
        end else begin
            storage_d = storage_q;
        end
    end

    // Storage register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            storage_q <= {WIDTH{1'b0}};
        end else begin
            storage_q <= storage_d;
        end
    end

    // Net cells present their drive combinationally; variable cells present storage.
    always_comb begin
        if (IS_NET == 1'b1) begin
            value_o    = cont_en_i ? cont_data_i : INIT_VAL;
            conflict_o = 1'b0;
        end else begin
            value_o    = storage_q;
            conflict_o = cont_en_i;
        end
    end

endmodule : svtypes_chan_cell

// File: rtl/svtypes_chan_bank.sv
// ----------------------------------------------------------------------------
// svtypes_chan_bank
// Bank of NCHAN typed channels (variable or net, chosen by NET_MASK).
// After reset an INIT sweep loads INIT_VAL into each variable channel, one
// channel per cycle, then the bank services procedural writes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_bus          : write bus (valid/ready/chan/data/err), slave side
//   cont_en_i       : per-channel continuous-drive enable
//   cont_data_i     : continuous-drive values, channel i at [i*WIDTH +: WIDTH]
//   rd_chan_i       : read select
//   rd_data_o       : registered read data (0 for an out-of-range select)
//   init_done_o     : INIT sweep complete
//   conflict_o      : sticky per-channel mixed-driver flags
//   conflict_cnt_o  : saturating conflict event count, only when
//                     SVTYPES_CONFLICT_CNT_EN is defined
// ----------------------------------------------------------------------------
module svtypes_chan_bank
    import svtypes_pkg::*;
#(
    parameter int                 WIDTH    = DEFAULT_WIDTH,
    parameter int                 NCHAN    = 4,
    parameter logic [WIDTH-1:0]   INIT_VAL = '0,
    parameter logic [NCHAN-1:0]   NET_MASK = '0,
    localparam int                CW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    svtypes_chan_bank_if.slave     wr_bus,
    input  logic [NCHAN-1:0]       cont_en_i,
    input  logic [NCHAN*WIDTH-1:0] cont_data_i,
    input  logic [CW-1:0]          rd_chan_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   init_done_o,
    output logic [NCHAN-1:0]       conflict_o
`ifdef SVTYPES_CONFLICT_CNT_EN
    ,
    output logic [7:0]             conflict_cnt_o
`endif
);

    localparam logic [CW-1:0] LAST_CH = CW'(NCHAN - 1);

    bank_state_t      state_q,     state_d;
    logic [CW-1:0]    init_ptr_q,  init_ptr_d;
    logic             init_done_q, init_done_d;
    logic             wr_ready_q,  wr_ready_d;
    logic             wr_err_q,    wr_err_d;
    logic [WIDTH-1:0] rd_data_q,   rd_data_d;
    logic [NCHAN-1:0] conflict_q,  conflict_d;

    logic             wr_accept_s;
    logic             wr_in_range_s;
    logic             wr_tgt_net_s;
    logic [NCHAN-1:0] cell_wr_en_s;
    logic [WIDTH-1:0] cell_wr_data_s;
    logic [WIDTH-1:0] cell_val_s   [NCHAN];
    logic [NCHAN-1:0] cell_confl_s;

    assign wr_accept_s   = wr_bus.wr_valid && wr_ready_q;
    assign wr_in_range_s = ({1'b0, wr_bus.wr_chan} < (CW+1)'(NCHAN));

    // Sequencer: INIT walks init_ptr across every channel once, then parks in IDLE.
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        init_done_d = init_done_q;
        wr_ready_d  = wr_ready_q;
        case (state_q)
            INIT: begin
                if (init_ptr_q == LAST_CH) begin
                    state_d     = IDLE;
                    init_ptr_d  = {CW{1'b0}};
                    init_done_d = 1'b1;
                    wr_ready_d  = 1'b1;
                end else begin
                    init_ptr_d  = init_ptr_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Per-channel write strobes: init-sweep writes in INIT, accepted bus writes in IDLE.
    always_comb begin
        cell_wr_en_s = {NCHAN{1'b0}};
        wr_tgt_net_s = 1'b0;
        if (state_q == INIT) begin
            cell_wr_data_s = INIT_VAL;
        end else begin
            cell_wr_data_s = wr_bus.wr_data;
        end
        for (int i = 0; i < NCHAN; i++) begin
            if ((state_q == INIT) && (init_ptr_q == CW'(i))) begin
                cell_wr_en_s[i] = ~NET_MASK[i];
            end else if (wr_accept_s && ({1'b0, wr_bus.wr_chan} == (CW+1)'(i))) begin
                cell_wr_en_s[i] = ~NET_MASK[i];
                wr_tgt_net_s    = NET_MASK[i];
            end else begin
                cell_wr_en_s[i] = 1'b0;
            end
        end
    end

    // Dropped-write flag: net target or index past the last channel.
    always_comb begin
        if (wr_accept_s) begin
            wr_err_d = wr_tgt_net_s || !wr_in_range_s;
        end else begin
            wr_err_d = 1'b0;
        end
    end

    // Read mux; an out-of-range select matches no channel and reads zero.
    always_comb begin
        rd_data_d = {WIDTH{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            rd_data_d = rd_data_d |
                (({1'b0, rd_chan_i} == (CW+1)'(i)) ? cell_val_s[i] : {WIDTH{1'b0}});
        end
    end

    assign conflict_d = conflict_q | cell_confl_s;

    // Channel cells.
    for (genvar g = 0; g < NCHAN; g++) begin : g_cell
        svtypes_chan_cell #(
            .WIDTH    (WIDTH),
            .IS_NET   (NET_MASK[g]),
            .INIT_VAL (INIT_VAL)
        ) u_cell (
            .clk_i       (clk),
            .rst_i       (rst),
            .wr_en_i     (cell_wr_en_s[g]),
            .wr_data_i   (cell_wr_data_s),
            .cont_en_i   (cont_en_i[g]),
            .cont_data_i (cont_data_i[g*WIDTH +: WIDTH]),
            .value_o     (cell_val_s[g]),
            .conflict_o  (cell_confl_s[g])
        );
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_ptr_q  <= {CW{1'b0}};
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_data_q   <= {WIDTH{1'b0}};
            conflict_q  <= {NCHAN{1'b0}};
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
            wr_ready_q  <= wr_ready_d;
            wr_err_q    <= wr_err_d;
            rd_data_q   <= rd_data_d;
            conflict_q  <= conflict_d;
        end
    end

    assign wr_bus.wr_ready = wr_ready_q;
    assign wr_bus.wr_err   = wr_err_q;
    assign rd_data_o       = rd_data_q;
    assign init_done_o     = init_done_q;
    assign conflict_o      = conflict_q;

`ifdef SVTYPES_CONFLICT_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] confl_pop_s;
    logic [8:0] cnt_sum_s;

    // Count of variable channels driven this edge, added with saturation at 255.
    always_comb begin
        confl_pop_s = 6'd0;
        for (int i = 0; i < NCHAN; i++) begin
            confl_pop_s = confl_pop_s + {5'd0, cell_confl_s[i]};
        end
        cnt_sum_s = {1'b0, cnt_q} + {3'd0, confl_pop_s};
        if (cnt_sum_s > 9'd255) begin
            cnt_d = 8'hFF;
        end else begin
            cnt_d = cnt_sum_s[7:0];
        end
    end

    // Conflict event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`endif

endmodule : svtypes_chan_bank

// File: tb/tb_svtypes_chan_bank.sv
// ----------------------------------------------------------------------------
// tb_svtypes_chan_bank
// Directed bench: NCHAN=4, NET_MASK=4'b0010 (ch1 is a net), INIT_VAL=8'h5A.
// Inputs change 1ns after a rising edge and outputs are sampled at the same
// point, so each tick() advances exactly one clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_svtypes_chan_bank;

    localparam int         WIDTH    = 8;
    localparam int         NCHAN    = 4;
    localparam logic [7:0] INIT_VAL = 8'h5A;
    localparam logic [3:0] NET_MASK = 4'b0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cont_en;
    logic [31:0] cont_data;
    logic [1:0]  rd_chan;
    logic [7:0]  rd_data;
    logic        init_done;
    logic [3:0]  conflict;
`ifdef SVTYPES_CONFLICT_CNT_EN
    logic [7:0]  conflict_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    svtypes_chan_bank_if #(.WIDTH(WIDTH), .NCHAN(NCHAN)) bus ();

    svtypes_chan_bank #(
        .WIDTH    (WIDTH),
        .NCHAN    (NCHAN),
        .INIT_VAL (INIT_VAL),
        .NET_MASK (NET_MASK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_bus         (bus),
        .cont_en_i      (cont_en),
        .cont_data_i    (cont_data),
        .rd_chan_i      (rd_chan),
        .rd_data_o      (rd_data),
        .init_done_o    (init_done),
        .conflict_o     (conflict)
`ifdef SVTYPES_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cont_en      = 4'b0000;
        cont_data    = 32'h0000_0000;
        rd_chan      = 2'd0;
        bus.wr_valid = 1'b0;
        bus.wr_chan  = 2'd0;
        bus.wr_data  = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_wr_ready",  {31'd0, bus.wr_ready}, 32'd0);
        check("rst_wr_err",    {31'd0, bus.wr_err}, 32'd0);
        check("rst_rd_data",   {24'd0, rd_data}, 32'd0);
        check("rst_conflict",  {28'd0, conflict}, 32'd0);

        // Init sweep: exactly 4 edges
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) check("init_done_at3", {31'd0, init_done}, 32'd0);
        end
        check("init_done_at4", {31'd0, init_done}, 32'd1);
        check("wr_ready_idle", {31'd0, bus.wr_ready}, 32'd1);
        check("rd_ch0_init",   {24'd0, rd_data}, 32'h5A);

        rd_chan = 2'd1;
        tick();
        check("rd_ch1_net_idle", {24'd0, rd_data}, 32'h5A);

        // Write C3 to variable ch2
        bus.wr_valid = 1'b1; bus.wr_chan = 2'd2; bus.wr_data = 8'hC3; rd_chan = 2'd2;
        tick();
        bus.wr_valid = 1'b0;
        check("wr2_err_n", {31'd0, bus.wr_err}, 32'd0);
        check("wr2_rd_old", {24'd0, rd_data}, 32'h5A);
        tick();
        check("wr2_rd_new", {24'd0, rd_data}, 32'hC3);
        check("wr2_err_n1", {31'd0, bus.wr_err}, 32'd0);

        // Write to net ch1: dropped, one-cycle wr_err
        bus.wr_valid = 1'b1; bus.wr_chan = 2'd1; bus.wr_data = 8'hFF; rd_chan = 2'd1;
        tick();
        bus.wr_valid = 1'b0;
        check("wr1_err_pulse", {31'd0, bus.wr_err}, 32'd1);
        tick();
        check("wr1_err_clear", {31'd0, bus.wr_err}, 32'd0);
        check("wr1_rd_keep",   {24'd0, rd_data}, 32'h5A);

        // Net ch1 driven: visible after one edge, no conflict
        cont_en = 4'b0010; cont_data = 32'h0000_7700;
        tick();
        check("net1_rd_drive", {24'd0, rd_data}, 32'h77);
        check("net1_no_confl", {28'd0, conflict}, 32'd0);
        cont_en = 4'b0000;
        tick();
        check("net1_rd_idle", {24'd0, rd_data}, 32'h5A);

        // ch3 continuous drive 11 with simultaneous write 22
        cont_en = 4'b1000; cont_data = 32'h1100_0000;
        bus.wr_valid = 1'b1; bus.wr_chan = 2'd3; bus.wr_data = 8'h22; rd_chan = 2'd3;
        tick();
        cont_en = 4'b0000; bus.wr_valid = 1'b0;
        check("confl3_flag",  {28'd0, conflict}, 32'h8);
        check("confl3_err_n", {31'd0, bus.wr_err}, 32'd0);
        tick();
        check("confl3_rd", {24'd0, rd_data}, 32'h11);
        check("confl3_sticky", {28'd0, conflict}, 32'h8);
`ifdef SVTYPES_CONFLICT_CNT_EN
        check("confl3_cnt", {24'd0, conflict_cnt}, 32'd1);
`endif

        // Hold cont_en[0] for 300 cycles
        cont_en = 4'b0001; cont_data = 32'h0000_0044; rd_chan = 2'd0;
        for (int k = 0; k < 300; k++) tick();
        cont_en = 4'b0000;
        check("hold0_confl", {28'd0, conflict}, 32'h9);
        check("hold0_rd",    {24'd0, rd_data}, 32'h44);
`ifdef SVTYPES_CONFLICT_CNT_EN
        check("hold0_cnt_sat", {24'd0, conflict_cnt}, 32'd255);
`endif

        // Reset in the 2nd init cycle after a conflict
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst2_confl", {28'd0, conflict}, 32'd0);
        check("rst2_init_done", {31'd0, init_done}, 32'd0);
`ifdef SVTYPES_CONFLICT_CNT_EN
        check("rst2_cnt", {24'd0, conflict_cnt}, 32'd0);
`endif
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) check("resweep_at3", {31'd0, init_done}, 32'd0);
        end
        check("resweep_at4", {31'd0, init_done}, 32'd1);
        check("resweep_rd0", {24'd0, rd_data}, 32'h5A);
        rd_chan = 2'd2;
        tick();
        check("resweep_rd2", {24'd0, rd_data}, 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_svtypes_chan_bank

// File: doc/svtypes_chan_bank.md
# svtypes_chan_bank

Parametrised bank of NCHAN typed storage channels. Each channel is configured as either a variable (procedurally written, holds value, initialised after reset) or a net (continuously driven, no storage). Variable channels that also receive a continuous drive are flagged as mixed-driver conflicts. The bank sits in the svtypes regression designs as the sequential successor to single-signal typedef/initialiser checks and exercises package typedefs, initial values and driver-mode rules under one clock.

## Interface
- WIDTH, 8, channel data width.
- NCHAN, 4, channel count, 2..32.
- INIT_VAL, 0, value loaded into every variable channel during the init sweep; also the idle value of net channels.
- NET_MASK, 0, NCHAN-bit mask; bit i = 1 makes channel i a net channel, 0 a variable channel.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  procedural write request.
- wr_ready  out  1  bank accepts a write this cycle.
- wr_chan  in  $clog2(NCHAN)  write target.
- wr_data  in  WIDTH  write data.
- wr_err  out  1  one-cycle pulse: the accepted write targeted a net channel or an index >= NCHAN.
- cont_en  in  NCHAN  per-channel continuous-drive enable.
- cont_data  in  NCHAN*WIDTH  continuous-drive values, channel i at [i*WIDTH +: WIDTH].
- rd_chan  in  $clog2(NCHAN)  read select.
- rd_data  out  WIDTH  registered read data.
- init_done  out  1  init sweep complete.
- conflict  out  NCHAN  sticky per-channel mixed-driver flags.
- conflict_cnt  out  8  saturating conflict event count (present only with the macro).

## Operation
- States: INIT, IDLE. Reset forces INIT, init_ptr=0, all storage=0, rd_data=0, init_done=0, wr_ready=0, wr_err=0, conflict=0, conflict_cnt=0.
- INIT: each cycle writes INIT_VAL into channel init_ptr when it is a variable channel (net channels are skipped but still take one cycle). init_ptr increments. After channel NCHAN-1 the next state is IDLE and init_done=1. The sweep lasts exactly NCHAN cycles.
- IDLE: wr_ready=1. A write is accepted on wr_valid&&wr_ready.
  - Variable channel target: storage updates at that edge.
  - Net channel target or out-of-range index: write is dropped and wr_err pulses the following cycle.
- Net channel i value: cont_data[i] when cont_en[i]=1, else INIT_VAL. This value is combinational and is never stored.
- Variable channel i with cont_en[i]=1: the continuous value overrides storage at that edge in any state, and conflict[i] is set. A simultaneous procedural write or INIT write to the same channel is lost, with no wr_err. conflict[i] clears only on rst.
- rd_data is updated every cycle with the current value of channel rd_chan (storage or net value). An out-of-range rd_chan reads 0.
- rst asserted mid-sweep or mid-write: the bank returns to INIT with no partial write retained.

## Timing
- Write accepted at edge N: storage valid after N; rd_data reflects it after edge N+1.
- Net channel: cont change before edge N appears on rd_data after edge N.
- wr_err: asserted for the cycle after the accepting edge.
- init_done rises NCHAN cycles after rst deasserts. The first write can be accepted on that cycle.

## Configuration
- SVTYPES_CONFLICT_CNT_EN defined: conflict_cnt exists. It increments by the number of variable channels with cont_en set at each edge, and saturates at 255.
- SVTYPES_CONFLICT_CNT_EN undefined: the port is absent, no counter logic is generated, and conflict flags are unchanged.

## Structure
- Package svtypes_pkg holds:
  - typedef enum logic {INIT, IDLE} bank_state_t
  - typedef logic svt_user_t
  - localparam DEFAULT_WIDTH=8
- Sub-module svtypes_chan_cell: one channel. Parameters: WIDTH, IS_NET, INIT_VAL. Ports: write strobe/data, cont_en/data. Outputs: value and conflict pulse. It is instantiated NCHAN times in a generate loop.

## Test plan
- NCHAN=4, NET_MASK=4'b0010, INIT_VAL=8'h5A, release rst: init_done high after 4 cycles; rd_chan=0 reads 8'h5A; rd_chan=1 with cont_en=0 reads 8'h5A.
- Write 8'hC3 to channel 2: rd_chan=2 returns 8'hC3 two edges after acceptance; wr_err stays 0.
- Write to channel 1 (net): rd_chan=1 keeps 8'h5A; wr_err pulses for exactly one cycle.
- cont_en[3]=1, cont_data ch3=8'h11, with a simultaneous write of 8'h22 to ch3: ch3 reads 8'h11; conflict=4'b1000; conflict_cnt=1 with macro.
- Hold cont_en[0] for 300 cycles with macro: conflict_cnt saturates at 255.
- Assert rst in the 2nd init cycle after a prior conflict: conflict clears to 0; the sweep restarts and takes 4 cycles.
